led_level_counter: RTL and testbench

- Produces the 6-bit level value COUNT that drives the thermometer-style LED bar stage directly downstream.
- Turns raw up/down pushbuttons into a saturating level in the range 0..MAX_COUNT.
- Each button goes through 2-FF synchronisation, then debounce, then single-step on press.
- Holding a button gives auto-repeat. A synchronous clear input returns the level to 0.

---
 rtl/led_level_counter.sv | 239 +++++++++++++++++++++++
 tb/tb_led_level_counter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/led_level_counter.sv
// Saturating 6-bit level counter driven by two raw pushbuttons.
// Each button is synchronised, debounced and edge-detected; a small FSM turns
// presses into single steps with auto-repeat while a button is held.

// Per-button conditioning: 2-FF synchroniser, debounce filter, rising-edge detect.
module led_level_counter_button #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic basys_clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    // Counter must hold DEBOUNCE_CYCLES-1; keep at least one bit for tiny overrides.
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic          level_prev;
    logic [DW-1:0] db_cnt;

    // Two flops bring the asynchronous button into the clock domain.
    always_ff @(posedge basys_clk) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge basys_clk) begin
        if (reset) begin
            level  <= 1'b0;
            db_cnt <= '0;
        end else if (sync == level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            level  <= sync;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DW'(1);
        end
    end

    // Previous debounced level, used to spot the press edge.
    always_ff @(posedge basys_clk) begin
        if (reset) begin
            level_prev <= 1'b0;
        end else begin
            level_prev <= level;
        end
    end

    assign rise = level & ~level_prev;

endmodule


module led_level_counter #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000,
    parameter int MAX_COUNT       = 16
) (
    input  logic       basys_clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       clear,
    output logic [5:0] COUNT,
    output logic       at_max,
    output logic       at_min,
    output logic       step_pulse
);

    // One shared timer serves both the initial hold delay and the repeat period,
    // so it is sized for whichever of the two is larger.
    localparam int TIMER_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW         = $clog2(TIMER_SPAN + 1);

    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);
    localparam logic [5:0]    MAX_LEVEL   = 6'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } state_t;

    state_t        state;
    logic          dir_up;
    logic [TW-1:0] timer;

    logic          up_level;
    logic          up_rise;
    logic          dn_level;
    logic          dn_rise;

    logic          abort;
    logic          step_req;
    logic          step_up;
    logic [5:0]    count_next;
    logic          moved;

    led_level_counter_button #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_up (
        .basys_clk (basys_clk),
        .reset     (reset),
        .raw       (btn_up),
        .level     (up_level),
        .rise      (up_rise)
    );

    led_level_counter_button #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_down (
        .basys_clk (basys_clk),
        .reset     (reset),
        .raw       (btn_down),
        .level     (dn_level),
        .rise      (dn_rise)
    );

    // Decide whether a step is requested this cycle and in which direction.
    // A hold sequence ends as soon as its button is released or the other one is held.
    always_comb begin
        abort    = dir_up ? (!up_level || dn_level) : (!dn_level || up_level);
        step_req = 1'b0;
        step_up  = dir_up;
        case (state)
            IDLE: begin
                if (up_rise && !dn_level) begin
                    step_req = 1'b1;
                    step_up  = 1'b1;
                end else if (dn_rise && !up_level) begin
                    step_req = 1'b1;
                    step_up  = 1'b0;
                end
            end
            DELAY: begin
                step_req = !abort && (timer == DELAY_LAST);
            end
            REPEAT: begin
                step_req = !abort && (timer == PERIOD_LAST);
            end
            default: begin
                step_req = 1'b0;
            end
        endcase
    end

    // Next level: clear wins, otherwise a step moves one unit unless already at a limit.
    always_comb begin
        count_next = COUNT;
        moved      = 1'b0;
        if (clear) begin
            count_next = '0;
        end else if (step_req) begin
            if (step_up && (COUNT != MAX_LEVEL)) begin
                count_next = COUNT + 6'd1;
                moved      = 1'b1;
            end else if (!step_up && (COUNT != 6'd0)) begin
                count_next = COUNT - 6'd1;
                moved      = 1'b1;
            end
        end
    end

    // Press / hold / auto-repeat sequencing; saturation never stops a repeat.
    always_ff @(posedge basys_clk) begin
        if (reset) begin
            state  <= IDLE;
            dir_up <= 1'b0;
            timer  <= '0;
        end else if (clear) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (step_req) begin
                        dir_up <= step_up;
                        timer  <= '0;
                        state  <= DELAY;
                    end
                end
                DELAY: begin
                    if (abort) begin
                        timer <= '0;
                        state <= IDLE;
                    end else if (timer == DELAY_LAST) begin
                        timer <= '0;
                        state <= REPEAT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                REPEAT: begin
                    if (abort) begin
                        timer <= '0;
                        state <= IDLE;
                    end else if (timer == PERIOD_LAST) begin
                        timer <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    timer <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Level and its flags are all registered from the same next value so they never disagree.
    always_ff @(posedge basys_clk) begin
        if (reset) begin
            COUNT      <= '0;
            at_max     <= 1'b0;
            at_min     <= 1'b1;
            step_pulse <= 1'b0;
        end else begin
            COUNT      <= count_next;
            at_max     <= (count_next == MAX_LEVEL);
            at_min     <= (count_next == 6'd0);
            step_pulse <= moved;
        end
    end

endmodule

// File: tb/tb_led_level_counter.sv
// Directed bench for led_level_counter with short debounce/repeat overrides.
module tb_led_level_counter;

    logic       basys_clk;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic       clear;
    logic [5:0] COUNT;
    logic       at_max;
    logic       at_min;
    logic       step_pulse;

    int checks;
    int errors;
    int pulseCount;
    int startPulses;

    led_level_counter #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(5),
        .MAX_COUNT(16)
    ) dut (
        .basys_clk  (basys_clk),
        .reset      (reset),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .clear      (clear),
        .COUNT      (COUNT),
        .at_max     (at_max),
        .at_min     (at_min),
        .step_pulse (step_pulse)
    );

    // 100 MHz clock.
    initial begin
        basys_clk = 1'b0;
        forever #5 basys_clk = ~basys_clk;
    end

    // Tally step strobes on the falling edge, well away from the active edge.
    initial pulseCount = 0;
    always @(negedge basys_clk) begin
        if (step_pulse === 1'b1) pulseCount++;
    end

    // Advance n rising edges and settle 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge basys_clk);
        #1;
    endtask

    // Drive the button/clear inputs and hold them for the given number of edges.
    task automatic applyStimulus(input logic up, input logic down, input logic clr, input int cycles);
        btn_up   = up;
        btn_down = down;
        clear    = clr;
        tick(cycles);
    endtask

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Short press that steps once and never reaches auto-repeat.
    task automatic tapButton(input logic isUp);
        applyStimulus(isUp, !isUp, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 8);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        clear    = 1'b0;

        // Reset then single tap.
        tick(3);
        checkOutput("reset_count", COUNT, 0);
        checkOutput("reset_at_min", at_min, 1);
        checkOutput("reset_at_max", at_max, 0);
        checkOutput("reset_pulse", step_pulse, 0);
        reset = 1'b0;
        startPulses = pulseCount;
        btn_up = 1'b1;
        tick(6);
        checkOutput("tap_before_latency", COUNT, 0);
        tick(1);
        checkOutput("tap_count", COUNT, 1);
        checkOutput("tap_pulse", step_pulse, 1);
        checkOutput("tap_at_min_falls", at_min, 0);
        tick(1);
        checkOutput("tap_pulse_single_cycle", step_pulse, 0);
        tick(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 8);
        checkOutput("tap_pulse_total", pulseCount - startPulses, 1);

        // Glitch rejection at COUNT=5.
        for (int i = 0; i < 4; i++) tapButton(1'b1);
        checkOutput("glitch_setup", COUNT, 5);
        startPulses = pulseCount;
        for (int w = 1; w <= 3; w++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, w);
            applyStimulus(1'b0, 1'b0, 1'b0, 6);
        end
        tick(4);
        checkOutput("glitch_count", COUNT, 5);
        checkOutput("glitch_pulses", pulseCount - startPulses, 0);

        // Auto-repeat and up saturation from 14.
        for (int i = 0; i < 9; i++) tapButton(1'b1);
        checkOutput("repeat_setup", COUNT, 14);
        startPulses = pulseCount;
        btn_up = 1'b1;
        tick(7);
        checkOutput("repeat_first", COUNT, 15);
        checkOutput("repeat_first_at_max", at_max, 0);
        tick(19);
        checkOutput("repeat_before_delay", COUNT, 15);
        tick(1);
        checkOutput("repeat_second", COUNT, 16);
        checkOutput("repeat_second_pulse", step_pulse, 1);
        checkOutput("repeat_second_at_max", at_max, 1);
        tick(5);
        checkOutput("repeat_saturated", COUNT, 16);
        checkOutput("repeat_saturated_pulse", step_pulse, 0);
        tick(28);
        checkOutput("repeat_hold_count", COUNT, 16);
        applyStimulus(1'b0, 1'b0, 1'b0, 8);
        checkOutput("repeat_pulses", pulseCount - startPulses, 2);
        checkOutput("repeat_at_max_end", at_max, 1);

        // Idle clear, then down saturation from 1.
        applyStimulus(1'b0, 1'b0, 1'b1, 1);
        checkOutput("clear_count", COUNT, 0);
        checkOutput("clear_at_min", at_min, 1);
        checkOutput("clear_at_max", at_max, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2);
        tapButton(1'b1);
        checkOutput("down_setup", COUNT, 1);
        startPulses = pulseCount;
        tapButton(1'b0);
        checkOutput("down_first", COUNT, 0);
        checkOutput("down_first_pulses", pulseCount - startPulses, 1);
        startPulses = pulseCount;
        tapButton(1'b0);
        checkOutput("down_second", COUNT, 0);
        checkOutput("down_second_pulses", pulseCount - startPulses, 0);
        checkOutput("down_at_min", at_min, 1);

        // Both buttons rising together give no step.
        startPulses = pulseCount;
        applyStimulus(1'b1, 1'b1, 1'b0, 12);
        applyStimulus(1'b0, 1'b0, 1'b0, 8);
        checkOutput("both_count", COUNT, 0);
        checkOutput("both_pulses", pulseCount - startPulses, 0);

        // Opposite button aborts an up repeat from 2.
        tapButton(1'b1);
        tapButton(1'b1);
        checkOutput("abort_setup", COUNT, 2);
        startPulses = pulseCount;
        applyStimulus(1'b1, 1'b0, 1'b0, 29);
        checkOutput("abort_in_repeat", COUNT, 4);
        applyStimulus(1'b1, 1'b1, 1'b0, 7);
        checkOutput("abort_at_36", COUNT, 5);
        tick(24);
        checkOutput("abort_frozen", COUNT, 5);
        applyStimulus(1'b0, 1'b0, 1'b0, 8);
        checkOutput("abort_pulses", pulseCount - startPulses, 3);

        // Clear during repeat with up still held.
        startPulses = pulseCount;
        applyStimulus(1'b1, 1'b0, 1'b0, 33);
        checkOutput("clear_rep_before", COUNT, 8);
        applyStimulus(1'b1, 1'b0, 1'b1, 1);
        checkOutput("clear_rep_count", COUNT, 0);
        checkOutput("clear_rep_pulse", step_pulse, 0);
        checkOutput("clear_rep_at_min", at_min, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 26);
        checkOutput("clear_rep_held", COUNT, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8);
        checkOutput("clear_rep_pulses", pulseCount - startPulses, 3);
        tapButton(1'b1);
        checkOutput("clear_rep_repress", COUNT, 1);

        // Reset during DELAY.
        applyStimulus(1'b1, 1'b0, 1'b0, 7);
        checkOutput("rst_delay_step", COUNT, 2);
        tick(3);
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1);
        checkOutput("rst_delay_count", COUNT, 0);
        checkOutput("rst_delay_at_min", at_min, 1);
        checkOutput("rst_delay_at_max", at_max, 0);
        checkOutput("rst_delay_pulse", step_pulse, 0);
        reset = 1'b0;
        tick(10);
        checkOutput("rst_after_count", COUNT, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
